bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 24, giving the number of bus sources and destinations (R0-R15, HI, LO, ZHI, ZLO, PC, MDR, Port, C).
REQ-002 SHALL have parameter SEL_W, default 5, giving the width of the encoded bus select.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port clear, input, 1, the reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, transfer request qualifier.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_src, input, NUM_SRC, one-hot source (Rout) mask; bit i = source code i.
REQ-008 SHALL have port req_dst, input, NUM_SRC, destination (Rin) mask; multiple bits allowed.
REQ-009 SHALL have port bus_sel, output, SEL_W, encoded select to the bus multiplexer.
REQ-010 SHALL have port load_en, output, NUM_SRC, per-register load enables.
REQ-011 SHALL have port xfer_done, output, 1, one-cycle pulse on completed transfer.
REQ-012 SHALL have port xfer_err, output, 1, one-cycle pulse on a rejected request.
REQ-013 SHALL have port err_code, output, 2, reason for the rejection, held until the next accepted request: 0 none, 1 no source, 2 multiple sources, 3 no destination.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, LOAD, DONE; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request when req_valid&&req_ready, capturing req_src and req_dst into registers.
REQ-016 SHALL, on accept with exactly one req_src bit set and req_dst nonzero, go IDLE->DRIVE.
REQ-017 SHALL, on accept with invalid masks, stay in IDLE, pulse xfer_err next cycle, set err_code, and assert no load_en.
REQ-018 SHALL give err_code precedence no source > multiple sources > no destination.
REQ-019 SHALL drive bus_sel = binary index of the captured source bit in DRIVE and LOAD, and SEL_NONE (31) otherwise.
REQ-020 SHALL assert load_en = captured req_dst only in LOAD, for exactly one cycle; zero in all other states.
REQ-021 SHALL go DRIVE->LOAD->DONE->IDLE unconditionally; xfer_done=1 only in DONE.
REQ-022 SHALL give latency accept-edge to xfer_done of 3 cycles; next accept possible the cycle after DONE.
REQ-023 SHALL allow req_src bit index equal to a req_dst bit (self-load); load_en includes that bit.
REQ-024 SHALL ignore req_src/req_dst changes after accept until return to IDLE.
REQ-025 SHALL mask req_src and req_dst bits at or above NUM_SRC to zero if SEL_W permits wider codes.

Reset
REQ-026 SHALL, on clear, go to IDLE and set req_ready=1, bus_sel=31, load_en=0, xfer_done=0, xfer_err=0, err_code=0, captured masks=0.
REQ-027 SHALL, on clear asserted in DRIVE or LOAD, abort the transfer with no load_en pulse on or after the clear edge.
REQ-028 SHALL give clear priority over an accept in the same cycle.

Configuration
REQ-029 SHALL, with macro XFER_STATS_EN defined, add outputs stat_done[15:0] and stat_err[15:0]: saturating counts of xfer_done and xfer_err pulses, zeroed by clear.
REQ-030 SHALL, with XFER_STATS_EN undefined, omit those ports and counters entirely; all other behaviour is identical.

Structure
REQ-031 SHALL take from shared package bus_pkg: SEL_W, NUM_SRC, SEL_NONE=5'd31, named select codes (SEL_R0..SEL_C = 0..23), the FSM state enum, and the err_code enum.
REQ-032 SHALL place the one-hot-to-binary encoder with population-count classification (zero/one/many) in sub-module src_encoder.

Verification
REQ-033 SHALL test: src=bit 21 (MDR), dst=bit 3 (R3) -> bus_sel=21 for 2 cycles, load_en=0x000008 in the LOAD cycle, xfer_done 3 cycles after accept.
REQ-034 SHALL test: src=0x000000 -> xfer_err pulse, err_code=1, load_en never nonzero, req_ready stays 1.
REQ-035 SHALL test: src=0x030000 (HI+LO) -> err_code=2; then src=bit 20, dst=0 -> err_code=3.
REQ-036 SHALL test: src=bit 5, dst=0x800021 -> load_en=0x800021 for one cycle; bus_sel=5.
REQ-037 SHALL test: clear asserted in the DRIVE cycle -> no load_en, bus_sel=31 next cycle, no xfer_done.
REQ-038 SHALL test, with XFER_STATS_EN defined: 65540 valid transfers -> stat_done=16'hFFFF saturates.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus transfer definitions: sizes, select codes, FSM states and error codes.
package bus_pkg;

    localparam int unsigned NUM_SRC = 24;
    localparam int unsigned SEL_W   = 5;

    localparam logic [4:0] SEL_NONE = 5'd31;

    localparam logic [4:0] SEL_R0   = 5'd0;
    localparam logic [4:0] SEL_R1   = 5'd1;
    localparam logic [4:0] SEL_R2   = 5'd2;
    localparam logic [4:0] SEL_R3   = 5'd3;
    localparam logic [4:0] SEL_R4   = 5'd4;
    localparam logic [4:0] SEL_R5   = 5'd5;
    localparam logic [4:0] SEL_R6   = 5'd6;
    localparam logic [4:0] SEL_R7   = 5'd7;
    localparam logic [4:0] SEL_R8   = 5'd8;
    localparam logic [4:0] SEL_R9   = 5'd9;
    localparam logic [4:0] SEL_R10  = 5'd10;
    localparam logic [4:0] SEL_R11  = 5'd11;
    localparam logic [4:0] SEL_R12  = 5'd12;
    localparam logic [4:0] SEL_R13  = 5'd13;
    localparam logic [4:0] SEL_R14  = 5'd14;
    localparam logic [4:0] SEL_R15  = 5'd15;
    localparam logic [4:0] SEL_HI   = 5'd16;
    localparam logic [4:0] SEL_LO   = 5'd17;
    localparam logic [4:0] SEL_ZHI  = 5'd18;
    localparam logic [4:0] SEL_ZLO  = 5'd19;
    localparam logic [4:0] SEL_PC   = 5'd20;
    localparam logic [4:0] SEL_MDR  = 5'd21;
    localparam logic [4:0] SEL_PORT = 5'd22;
    localparam logic [4:0] SEL_C    = 5'd23;

    typedef enum logic [1:0] {StIdle, StDrive, StLoad, StDone} xfer_state_e;

    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrNoSrc    = 2'd1,
        ErrMultiSrc = 2'd2,
        ErrNoDst    = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {SrcZero, SrcOne, SrcMany} src_class_e;

endpackage

// File: rtl/src_encoder.sv
// One-hot to binary encoder that also classifies the mask as zero, one or many bits set.
module src_encoder
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SRC = bus_pkg::NUM_SRC,
    parameter int unsigned SEL_W   = bus_pkg::SEL_W
) (
    input  logic [NUM_SRC-1:0] mask,
    output logic [SEL_W-1:0]   idx,
    output logic [1:0]         cls
);

    logic seen;
    logic many;

    always_comb begin
        seen = 1'b0;
        many = 1'b0;
        idx  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mask[i]) begin
                many = many | seen;
                seen = 1'b1;
                idx  = SEL_W'(i);
            end
        end
        cls = many ? SrcMany : (seen ? SrcOne : SrcZero);
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register bus transfer sequencer (IDLE -> DRIVE -> LOAD -> DONE).
// Define XFER_STATS_EN to add saturating stat_done/stat_err counters.
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned NUM_SRC = bus_pkg::NUM_SRC,
    parameter int unsigned SEL_W   = bus_pkg::SEL_W
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUM_SRC-1:0] req_src,
    input  logic [NUM_SRC-1:0] req_dst,
    output logic [SEL_W-1:0]   bus_sel,
    output logic [NUM_SRC-1:0] load_en,
    output logic               xfer_done,
    output logic               xfer_err,
    output logic [1:0]         err_code
`ifdef XFER_STATS_EN
    ,
    output logic [15:0]        stat_done,
    output logic [15:0]        stat_err
`endif
);

    localparam logic [SEL_W-1:0] SelIdle = SEL_W'(SEL_NONE);

    xfer_state_e        state;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] dst_q;
    logic [NUM_SRC-1:0] enc_in;
    logic [SEL_W-1:0]   enc_idx;
    logic [1:0]         enc_cls;
    logic               accept;

    // Classify the live request while idle; re-encode the captured source once busy.
    assign enc_in = (state == StIdle) ? req_src : src_q;
    assign accept = req_valid && req_ready;

    src_encoder #(
        .NUM_SRC(NUM_SRC),
        .SEL_W  (SEL_W)
    ) u_src_encoder (
        .mask(enc_in),
        .idx (enc_idx),
        .cls (enc_cls)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= StIdle;
            req_ready <= 1'b1;
            bus_sel   <= SelIdle;
            load_en   <= '0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            err_code  <= ErrNone;
            src_q     <= '0;
            dst_q     <= '0;
        end else begin
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            load_en   <= '0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        src_q <= req_src;
                        dst_q <= req_dst;
                        if (enc_cls == SrcOne && |req_dst) begin
                            state     <= StDrive;
                            req_ready <= 1'b0;
                            bus_sel   <= enc_idx;
                            err_code  <= ErrNone;
                        end else begin
                            xfer_err <= 1'b1;
                            err_code <= (enc_cls == SrcZero) ? ErrNoSrc :
                                        (enc_cls == SrcMany) ? ErrMultiSrc : ErrNoDst;
                        end
                    end
                end
                StDrive: begin
                    state   <= StLoad;
                    bus_sel <= enc_idx;
                    load_en <= dst_q;
                end
                StLoad: begin
                    state     <= StDone;
                    bus_sel   <= SelIdle;
                    xfer_done <= 1'b1;
                end
                StDone: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= StIdle;
                    req_ready <= 1'b1;
                    bus_sel   <= SelIdle;
                end
            endcase
        end
    end

`ifdef XFER_STATS_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            stat_done <= '0;
            stat_err  <= '0;
        end else begin
            if (xfer_done && stat_done != 16'hFFFF) begin
                stat_done <= stat_done + 16'd1;
            end
            if (xfer_err && stat_err != 16'hFFFF) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed self-checking bench for bus_xfer_ctrl; stats checks need XFER_STATS_EN.
module tb_bus_xfer_ctrl;

    logic        clock;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_src;
    logic [23:0] req_dst;
    logic [4:0]  bus_sel;
    logic [23:0] load_en;
    logic        xfer_done;
    logic        xfer_err;
    logic [1:0]  err_code;
`ifdef XFER_STATS_EN
    logic [15:0] stat_done;
    logic [15:0] stat_err;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    bus_xfer_ctrl #(
        .NUM_SRC(24),
        .SEL_W  (5)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_src  (req_src),
        .req_dst  (req_dst),
        .bus_sel  (bus_sel),
        .load_en  (load_en),
        .xfer_done(xfer_done),
        .xfer_err (xfer_err),
        .err_code (err_code)
`ifdef XFER_STATS_EN
        ,
        .stat_done(stat_done),
        .stat_err (stat_err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear     = 1'b1;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        tick();
        tick();

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_sel",   32'(bus_sel),   32'd31);
        chk("rst_load",  32'(load_en),   32'd0);
        chk("rst_done",  32'(xfer_done), 32'd0);
        chk("rst_err",   32'(xfer_err),  32'd0);
        chk("rst_code",  32'(err_code),  32'd0);
        clear = 1'b0;
        tick();

        // MDR -> R3; garbage on the request lines while busy must be ignored
        req_valid = 1'b1;
        req_src   = 24'h200000;
        req_dst   = 24'h000008;
        tick();
        req_src = 24'hFFFFFF;
        req_dst = 24'h000001;
        chk("mdr_drive_sel",   32'(bus_sel),   32'd21);
        chk("mdr_drive_ready", 32'(req_ready), 32'd0);
        chk("mdr_drive_load",  32'(load_en),   32'd0);
        tick();
        chk("mdr_load_sel",  32'(bus_sel),   32'd21);
        chk("mdr_load_en",   32'(load_en),   32'h000008);
        chk("mdr_load_done", 32'(xfer_done), 32'd0);
        tick();
        chk("mdr_done",      32'(xfer_done), 32'd1);
        chk("mdr_done_load", 32'(load_en),   32'd0);
        chk("mdr_done_sel",  32'(bus_sel),   32'd31);
        req_valid = 1'b0;
        tick();
        chk("mdr_idle_ready", 32'(req_ready), 32'd1);
        chk("mdr_idle_done",  32'(xfer_done), 32'd0);

        // No source
        req_valid = 1'b1;
        req_src   = 24'h000000;
        req_dst   = 24'h000008;
        tick();
        req_valid = 1'b0;
        chk("nosrc_err",   32'(xfer_err),  32'd1);
        chk("nosrc_code",  32'(err_code),  32'd1);
        chk("nosrc_ready", 32'(req_ready), 32'd1);
        chk("nosrc_load",  32'(load_en),   32'd0);
        tick();
        chk("nosrc_err_pulse", 32'(xfer_err),  32'd0);
        chk("nosrc_code_held", 32'(err_code),  32'd1);
        chk("nosrc_load2",     32'(load_en),   32'd0);
        chk("nosrc_ready2",    32'(req_ready), 32'd1);

        // Multiple sources, then no destination, back to back
        req_valid = 1'b1;
        req_src   = 24'h030000;
        req_dst   = 24'h000008;
        tick();
        chk("multi_code", 32'(err_code), 32'd2);
        chk("multi_err",  32'(xfer_err), 32'd1);
        req_src = 24'h100000;
        req_dst = 24'h000000;
        tick();
        chk("nodst_code", 32'(err_code), 32'd3);
        chk("nodst_err",  32'(xfer_err), 32'd1);
        chk("nodst_load", 32'(load_en),  32'd0);

        // Precedence: no source beats no destination, multiple beats no destination
        req_src = 24'h000000;
        tick();
        chk("prec_nosrc", 32'(err_code), 32'd1);
        req_src = 24'h030000;
        tick();
        chk("prec_multi", 32'(err_code), 32'd2);
        req_valid = 1'b0;
        tick();

        // R5 -> R0, R5, C
        req_valid = 1'b1;
        req_src   = 24'h000020;
        req_dst   = 24'h800021;
        tick();
        req_valid = 1'b0;
        chk("r5_drive_sel", 32'(bus_sel),  32'd5);
        chk("r5_code_clr",  32'(err_code), 32'd0);
        tick();
        chk("r5_load_sel", 32'(bus_sel), 32'd5);
        chk("r5_load_en",  32'(load_en), 32'h800021);
        tick();
        chk("r5_done_load", 32'(load_en),   32'd0);
        chk("r5_done",      32'(xfer_done), 32'd1);
        tick();

        // Self-load: R7 -> R7, R0
        req_valid = 1'b1;
        req_src   = 24'h000080;
        req_dst   = 24'h000081;
        tick();
        req_valid = 1'b0;
        tick();
        chk("self_load_en", 32'(load_en), 32'h000081);
        chk("self_sel",     32'(bus_sel), 32'd7);
        tick();
        tick();

        // Clear during DRIVE aborts the transfer
        req_valid = 1'b1;
        req_src   = 24'h000002;
        req_dst   = 24'h000004;
        tick();
        req_valid = 1'b0;
        chk("abort_in_drive", 32'(bus_sel), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_sel",   32'(bus_sel),   32'd31);
        chk("abort_load",  32'(load_en),   32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        tick();
        chk("abort_load2", 32'(load_en),   32'd0);
        chk("abort_done",  32'(xfer_done), 32'd0);
        tick();
        chk("abort_done2", 32'(xfer_done), 32'd0);

        // Clear wins over a simultaneous valid accept
        req_valid = 1'b1;
        req_src   = 24'h000004;
        req_dst   = 24'h000008;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        req_valid = 1'b0;
        chk("clrpri_ready", 32'(req_ready), 32'd1);
        chk("clrpri_sel",   32'(bus_sel),   32'd31);
        tick();
        chk("clrpri_load", 32'(load_en), 32'd0);

`ifdef XFER_STATS_EN
        chk("stat_done_zero", 32'(stat_done), 32'd0);
        req_valid = 1'b1;
        req_src   = 24'h000000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("stat_err_one", 32'(stat_err), 32'd1);
        req_src = 24'h000001;
        req_dst = 24'h000002;
        for (int n = 0; n < 65540; n++) begin
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            tick();
            tick();
            tick();
        end
        tick();
        chk("stat_done_sat", 32'(stat_done), 32'hFFFF);
        chk("stat_err_hold", 32'(stat_err),  32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
